// File: rtl/dc02_pkg.sv
// Shared definitions for the DC02 terminal multiplexor blocks.
//   - NLINES_MAX : upper bound on terminal lines any DC02 block serves
//   - line_idx_t : 3-bit line number carried with every character
//   - tx_state_e : printer-side scheduler FSM states
//   - ARM_STAT_* : bit positions of the ARM-visible DC02 status word, so the
//                  busy vector read by the ARM lines up with the register block
package dc02_pkg;

  localparam int NLINES_MAX = 8;

  typedef logic [2:0] line_idx_t;

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_OFFER = 1'b1
  } tx_state_e;

  // ARM status word: [7:0] printer pacing busy, [15:8] printer buffer full.
  localparam int ARM_STAT_BUSY_LSB   = 0;
  localparam int ARM_STAT_BUSY_MSB   = ARM_STAT_BUSY_LSB + NLINES_MAX - 1;
  localparam int ARM_STAT_PRFULL_LSB = ARM_STAT_BUSY_MSB + 1;
  localparam int ARM_STAT_PRFULL_MSB = ARM_STAT_PRFULL_LSB + NLINES_MAX - 1;

endpackage

// File: rtl/dc02_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request bit per line
//   ptr       : line to consider first (must be < N)
//   gnt_idx   : first requesting line at or after ptr, wrapping modulo N
//   gnt_valid : at least one request present
module dc02_rr_arbiter
  import dc02_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  input  line_idx_t    ptr,
  output line_idx_t    gnt_idx,
  output logic         gnt_valid
);

  always_comb begin
    int j;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = line_idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/dc02_tx_scheduler.sv
// DC02 printer-side transmit scheduler.
// Scans the printer-buffer-full bits round-robin, hands one character at a
// time (with its line number) to a shared byte channel, then paces each line
// at emulated character time before signalling the printer ready again.
//   CLOCK, RESET : clock, synchronous active-high reset
//   enable       : gates new grants; an offer already made still completes
//   prfulls      : buffer-full bit per line (from DC02)
//   prchars      : 12-bit character per line, line n at [12n+11:12n]
//   prfull_clr   : one-cycle pulse, character of line n latched
//   prflag_set   : one-cycle pulse, line n character time elapsed
//   out_valid/out_ready/out_line/out_char : downstream byte channel
//   busy         : line n is pacing
//   state_dbg    : current FSM state (0 = SCAN, 1 = OFFER)
//
// Handshake: out_valid rises with a stable {out_line, out_char} and stays
// high, payload unchanged, until the first cycle where out_ready is also high;
// the transfer happens on that clock edge. out_ready may be high beforehand.
module dc02_tx_scheduler
  import dc02_pkg::*;
#(
  parameter int NLINES  = 6,
  parameter int PACEDIV = 100000,
  parameter int TMRW    = 17
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 enable,
  input  logic [NLINES-1:0]    prfulls,
  input  logic [NLINES*12-1:0] prchars,
  output logic [NLINES-1:0]    prfull_clr,
  output logic [NLINES-1:0]    prflag_set,
  output logic                 out_valid,
  output logic [2:0]           out_line,
  output logic [7:0]           out_char,
  input  logic                 out_ready,
  output logic [NLINES-1:0]    busy,
  output logic                 state_dbg
);

  tx_state_e          state_q, state_d;
  logic               out_valid_q, out_valid_d;
  line_idx_t          line_q, line_d;
  logic [7:0]         char_q, char_d;
  logic [NLINES-1:0]  clr_q, clr_d;
  logic [NLINES-1:0]  pend_q, pend_d;
  line_idx_t          rr_q, rr_d;
  logic [NLINES-1:0]  accept_v;
  logic [NLINES-1:0]  busy_v;
  logic [NLINES-1:0]  flag_v;
  logic [NLINES-1:0]  eligible;
  line_idx_t          gnt_idx;
  logic               gnt_valid;

  // pend covers the window between the grant and the DC02 dropping prfull,
  // so the same character is never granted twice.
  assign eligible = prfulls & ~busy_v & ~pend_q;

  dc02_rr_arbiter #(.N(NLINES)) u_arb (
    .req       (eligible),
    .ptr       (rr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    line_d      = line_q;
    char_d      = char_q;
    clr_d       = '0;
    pend_d      = pend_q;
    rr_d        = rr_q;
    accept_v    = '0;
    case (state_q)
      ST_SCAN: begin
        if (enable && gnt_valid) begin
          state_d         = ST_OFFER;
          out_valid_d     = 1'b1;
          line_d          = gnt_idx;
          char_d          = prchars[12*int'(gnt_idx) +: 8];
          clr_d[gnt_idx]  = 1'b1;
          pend_d[gnt_idx] = 1'b1;
          rr_d            = (int'(gnt_idx) == NLINES - 1) ? '0 : gnt_idx + 3'd1;
        end
      end
      ST_OFFER: begin
        if (out_valid_q && out_ready) begin
          state_d          = ST_SCAN;
          out_valid_d      = 1'b0;
          pend_d[line_q]   = 1'b0;
          accept_v[line_q] = 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_SCAN;
      out_valid_q <= 1'b0;
      line_q      <= '0;
      char_q      <= '0;
      clr_q       <= '0;
      pend_q      <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      line_q      <= line_d;
      char_q      <= char_d;
      clr_q       <= clr_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
    end
  end

  // Per-line pacing timers. The flag pulse is decoded from the timer having
  // reached zero, so it lands PACEDIV+1 cycles after acceptance.
  for (genvar n = 0; n < NLINES; n++) begin : g_pace
    logic [TMRW-1:0] timer_q, timer_d;
    logic            busy_q, busy_d;

    always_comb begin
      timer_d = timer_q;
      busy_d  = busy_q;
      if (accept_v[n]) begin
        busy_d  = 1'b1;
        timer_d = TMRW'(PACEDIV);
      end else if (busy_q) begin
        if (timer_q == '0) busy_d = 1'b0;
        else               timer_d = timer_q - TMRW'(1);
      end
    end

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        timer_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        timer_q <= timer_d;
        busy_q  <= busy_d;
      end
    end

    assign busy_v[n] = busy_q;
    assign flag_v[n] = busy_q && (timer_q == '0);
  end

  assign prfull_clr = clr_q;
  assign prflag_set = flag_v;
  assign out_valid  = out_valid_q;
  assign out_line   = line_q;
  assign out_char   = char_q;
  assign busy       = busy_v;
  assign state_dbg  = logic'(state_q);

endmodule

// File: tb/tb_dc02_tx_scheduler.sv
// Bench for dc02_tx_scheduler: a paced instance (PACEDIV=4) for the main
// scenarios and an unpaced instance (PACEDIV=0) for the fairness rotation.
module tb_dc02_tx_scheduler;

  localparam int NL = 6;
  localparam int PD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             en = 1'b1, rdy = 1'b0;
  logic [NL-1:0]    pf = '0;
  logic [NL*12-1:0] pc = '0;
  logic [NL-1:0]    clr, flag, busy;
  logic             ov, st;
  logic [2:0]       ol;
  logic [7:0]       oc;

  logic             rdy0 = 1'b0;
  logic [NL-1:0]    pf0 = '0;
  logic [NL*12-1:0] pc0 = '0;
  logic [NL-1:0]    clr0, flag0, busy0;
  logic             ov0, st0;
  logic [2:0]       ol0;
  logic [7:0]       oc0;

  dc02_tx_scheduler #(.NLINES(NL), .PACEDIV(PD), .TMRW(8)) u_dut (
    .CLOCK(clk), .RESET(rst), .enable(en), .prfulls(pf), .prchars(pc),
    .prfull_clr(clr), .prflag_set(flag), .out_valid(ov), .out_line(ol),
    .out_char(oc), .out_ready(rdy), .busy(busy), .state_dbg(st)
  );

  dc02_tx_scheduler #(.NLINES(NL), .PACEDIV(0), .TMRW(1)) u_dut0 (
    .CLOCK(clk), .RESET(rst), .enable(1'b1), .prfulls(pf0), .prchars(pc0),
    .prfull_clr(clr0), .prflag_set(flag0), .out_valid(ov0), .out_line(ol0),
    .out_char(oc0), .out_ready(rdy0), .busy(busy0), .state_dbg(st0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // scoreboard: {line, char} of every character written and not yet delivered
  logic [10:0] exp_q[$];

  // ---------------- driver helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_char(input int n, input logic [11:0] v);
    pc[12*n +: 12] = v;
  endtask

  function automatic int find_line(input logic [2:0] l);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][10:8] == l) return i;
    return -1;
  endfunction

  task automatic wait_idle;
    int c;
    c = 0;
    rdy = 1'b1;
    en  = 1'b1;
    pf  = '0;
    while ((ov || busy != '0) && c < 100) begin
      tick;
      c++;
    end
    n_tests++;
    if (ov || busy != '0) begin
      n_fail++;
      $display("FAIL wait_idle: out_valid=%b busy=%b after %0d cycles, want idle", ov, busy, c);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int bad;
    rst = 1'b1; pf = '0; rdy = 1'b0; en = 1'b1;
    tick; tick;
    n_tests++;
    if (ov !== 1'b0 || ol !== 3'd0 || oc !== 8'd0 || st !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b line=%0d char=%h state=%b, want all 0", ov, ol, oc, st);
    end
    n_tests++;
    if (clr !== '0 || flag !== '0 || busy !== '0 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vectors: clr=%b flag=%b busy=%b valid0=%b, want 0", clr, flag, busy, ov0);
    end
    rst = 1'b0;
    tick;
    // reset in the middle of an offer
    set_char(3, 12'o0132);
    pf = 6'b001000;
    tick;
    n_tests++;
    if (ov !== 1'b1 || ol !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_pre_offer: valid=%b line=%0d, want 1 / 3", ov, ol);
    end
    pf  = '0;
    rst = 1'b1;
    tick;
    n_tests++;
    if (ov !== 1'b0 || busy !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_offer: valid=%b busy=%b, want 0 / 0", ov, busy);
    end
    rst = 1'b0;
    rdy = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (flag !== '0 || ov !== 1'b0 || busy !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_dropped_line: %0d cycles with activity, want 0", bad);
    end
  endtask

  task automatic test_single_line;
    logic [NL-1:0] want;
    int bad;
    set_char(2, 12'o0101);
    pf  = 6'b000100;
    rdy = 1'b1;
    tick;  // t+1
    n_tests++;
    if (clr !== 6'b000100 || ov !== 1'b1 || ol !== 3'd2 || oc !== 8'h41) begin
      n_fail++;
      $display("FAIL single_grant: clr=%b valid=%b line=%0d char=%h, want 000100/1/2/41", clr, ov, ol, oc);
    end
    pf  = '0;
    bad = 0;
    for (int k = 2; k <= PD + 6; k++) begin
      tick;
      want = (k == PD + 2) ? 6'b000100 : 6'b000000;
      if (flag !== want) bad++;
      if (k == 2) begin
        n_tests++;
        if (ov !== 1'b0 || busy !== 6'b000100) begin
          n_fail++;
          $display("FAIL single_accept: valid=%b busy=%b, want 0 / 000100", ov, busy);
        end
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_flag_time: %0d cycles off, want flag only at t+%0d", bad, PD + 2);
    end
    n_tests++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL single_busy_end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_round_robin;
    int got[$];
    logic [NL-1:0] prev_acc;
    int bad_flag, bad_char, want;
    prev_acc = '0; bad_flag = 0; bad_char = 0;
    for (int n = 0; n < NL; n++) pc0[12*n +: 12] = 12'h030 + 12'(n);
    pf0  = '1;
    rdy0 = 1'b1;
    for (int c = 0; c < 80 && got.size() < 7; c++) begin
      tick;
      if (flag0 !== prev_acc) bad_flag++;
      prev_acc = '0;
      if (ov0 && rdy0) begin
        got.push_back(int'(ol0));
        if (oc0 !== 8'h30 + 8'(ol0)) bad_char++;
        prev_acc[ol0] = 1'b1;
      end
      if (got.size() == 7) pf0 = '0;
    end
    tick;
    if (flag0 !== prev_acc) bad_flag++;
    n_tests++;
    if (got.size() != 7) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, want 7", got.size());
    end
    for (int i = 0; i < 7; i++) begin
      want = i % NL;
      n_tests++;
      if (i >= got.size() || got[i] != want) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, want);
      end
    end
    n_tests++;
    if (bad_flag != 0) begin
      n_fail++;
      $display("FAIL rr_flag_nopace: %0d cycles wrong, want flag the cycle after acceptance", bad_flag);
    end
    n_tests++;
    if (bad_char != 0) begin
      n_fail++;
      $display("FAIL rr_char: %0d wrong characters, want 0", bad_char);
    end
    rdy0 = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad;
    set_char(1, 12'h05A);
    pf  = 6'b000010;
    rdy = 1'b0;
    tick;  // t+1
    n_tests++;
    if (clr !== 6'b000010 || ov !== 1'b1 || ol !== 3'd1 || oc !== 8'h5A) begin
      n_fail++;
      $display("FAIL bp_grant: clr=%b valid=%b line=%0d char=%h, want 000010/1/1/5a", clr, ov, ol, oc);
    end
    set_char(1, 12'h0A5);  // source changes while stalled; offer must not
    bad = 0;
    for (int k = 2; k <= 5; k++) begin
      tick;
      if (ov !== 1'b1 || ol !== 3'd1 || oc !== 8'h5A || clr !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
    end
    rdy = 1'b1;
    pf  = '0;
    tick;
    n_tests++;
    if (ov !== 1'b0 || busy !== 6'b000010 || clr !== '0) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b busy=%b clr=%b, want 0/000010/0", ov, busy, clr);
    end
  endtask

  task automatic test_enable;
    int bad;
    en  = 1'b0;
    rdy = 1'b0;
    set_char(0, 12'o0141);
    pf  = 6'b000001;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ov !== 1'b0 || clr !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_gate: %0d grant cycles while disabled, want 0", bad);
    end
    en = 1'b1;
    tick;
    n_tests++;
    if (clr !== 6'b000001 || ov !== 1'b1 || ol !== 3'd0 || oc !== 8'h61) begin
      n_fail++;
      $display("FAIL en_grant: clr=%b valid=%b line=%0d char=%h, want 000001/1/0/61", clr, ov, ol, oc);
    end
    pf = '0;
    en = 1'b0;
    tick; tick;
    n_tests++;
    if (ov !== 1'b1) begin
      n_fail++;
      $display("FAIL en_offer_kept: valid=%b, want 1", ov);
    end
    rdy = 1'b1;
    tick;
    n_tests++;
    if (ov !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL en_accept: valid=%b busy0=%b, want 0 / 1", ov, busy[0]);
    end
    en = 1'b1;
  endtask

  task automatic test_concurrent;
    int acc_c[2];
    int flg_c[2];
    bit both;
    acc_c = '{-1, -1}; flg_c = '{-1, -1}; both = 1'b0;
    set_char(0, 12'h011);
    set_char(1, 12'h022);
    pf  = 6'b000011;
    rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (clr != '0) pf = pf & ~clr;
      if (ov && rdy && ol < 3'd2) acc_c[ol[0]] = cyc;
      for (int n = 0; n < 2; n++)
        if (flag[n] && flg_c[n] < 0) flg_c[n] = cyc;
      if (busy[1:0] == 2'b11) both = 1'b1;
    end
    for (int n = 0; n < 2; n++) begin
      n_tests++;
      if (acc_c[n] < 0 || flg_c[n] != acc_c[n] + PD + 1) begin
        n_fail++;
        $display("FAIL conc_flag%0d: flag at %0d, want %0d", n, flg_c[n], acc_c[n] + PD + 1);
      end
    end
    n_tests++;
    if (!both || busy !== '0) begin
      n_fail++;
      $display("FAIL conc_busy: overlap=%b final busy=%b, want 1 / 0", both, busy);
    end
  endtask

  task automatic test_random;
    logic [NL-1:0] ready_sw, pend_fl;
    int acc_c[NL];
    logic prev_ov, prev_rdy;
    logic [2:0] prev_ol;
    logic [7:0] prev_oc;
    logic [11:0] ch;
    int idx, qi;
    bit writes;
    ready_sw = '1; pend_fl = '0; prev_ov = 1'b0; prev_rdy = 1'b0;
    prev_ol = '0; prev_oc = '0;
    pf = '0;
    exp_q.delete();
    for (int n = 0; n < NL; n++) acc_c[n] = 0;
    for (int c = 0; c < 1700; c++) begin
      writes = (c < 1400);
      tick;
      n_tests++;
      if ($countones(clr) > 1) begin
        n_fail++;
        $display("FAIL rnd_clr_onehot: clr=%b, want at most one bit", clr);
      end
      if (clr != '0) begin
        idx = 0;
        for (int n = 0; n < NL; n++) if (clr[n]) idx = n;
        qi = find_line(3'(idx));
        n_tests++;
        if (!pf[idx] || ov !== 1'b1 || int'(ol) != idx || qi < 0 || oc !== exp_q[qi][7:0]) begin
          n_fail++;
          $display("FAIL rnd_grant: clr line %0d full=%b valid=%b line=%0d char=%h want char %h",
                   idx, pf[idx], ov, ol, oc, (qi < 0) ? 8'h00 : exp_q[qi][7:0]);
        end
        pf[idx] = 1'b0;
      end
      if (prev_ov && !prev_rdy) begin
        n_tests++;
        if (ov !== 1'b1 || ol !== prev_ol || oc !== prev_oc) begin
          n_fail++;
          $display("FAIL rnd_stall: valid=%b line=%0d char=%h, want 1/%0d/%h", ov, ol, oc, prev_ol, prev_oc);
        end
      end
      for (int n = 0; n < NL; n++) begin
        if (flag[n]) begin
          n_tests++;
          if (!pend_fl[n] || cyc != acc_c[n] + PD + 1) begin
            n_fail++;
            $display("FAIL rnd_flag%0d: flag at %0d pending=%b, want at %0d", n, cyc, pend_fl[n], acc_c[n] + PD + 1);
          end
          pend_fl[n]  = 1'b0;
          ready_sw[n] = 1'b1;
        end else if (pend_fl[n] && cyc > acc_c[n] + PD + 1) begin
          n_tests++;
          n_fail++;
          $display("FAIL rnd_flag_missing%0d: no flag by %0d, want at %0d", n, cyc, acc_c[n] + PD + 1);
          pend_fl[n] = 1'b0;
        end
      end
      rdy = writes ? ($urandom_range(0, 3) != 0) : 1'b1;
      en  = writes ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (writes) begin
        for (int n = 0; n < NL; n++) begin
          if (ready_sw[n] && !pf[n] && $urandom_range(0, 3) == 0) begin
            ch = 12'($urandom);
            set_char(n, ch);
            pf[n]       = 1'b1;
            ready_sw[n] = 1'b0;
            exp_q.push_back({3'(n), ch[7:0]});
          end
        end
      end
      if (ov && rdy) begin
        qi = find_line(ol);
        n_tests++;
        if (qi < 0 || exp_q[qi][7:0] !== oc) begin
          n_fail++;
          $display("FAIL rnd_accept: line %0d char %h not expected (queue idx %0d)", ol, oc, qi);
        end else begin
          exp_q.delete(qi);
        end
        if (int'(ol) < NL) begin
          pend_fl[ol] = 1'b1;
          acc_c[ol]   = cyc;
        end
      end
      prev_ov = ov; prev_rdy = rdy; prev_ol = ol; prev_oc = oc;
    end
    n_tests++;
    if (exp_q.size() != 0 || pend_fl != '0 || busy !== '0) begin
      n_fail++;
      $display("FAIL rnd_drain: %0d undelivered, pending=%b busy=%b, want 0/0/0", exp_q.size(), pend_fl, busy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_single_line;
    wait_idle;
    test_round_robin;
    test_backpressure;
    wait_idle;
    test_enable;
    wait_idle;
    test_concurrent;
    wait_idle;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
